// File: rtl/saturn_bus_arbiter_pkg.sv
// Shared definitions for the Saturn nibble-bus arbiter: FSM states, owner codes
// and phase constants.
package saturn_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_t;

  localparam logic [1:0] PHASE_ARB  = 2'd0;
  localparam logic [1:0] PHASE_LAST = 2'd3;

  function automatic logic [3:0] phase_onehot(input logic [1:0] phase);
    return 4'b0001 << phase;
  endfunction

endpackage

// File: rtl/saturn_phase_gen.sv
// Free-running four-phase sequencer: current phase, one-hot phase strobes and a
// count of completed four-phase cycles.
module saturn_phase_gen
  import saturn_bus_arbiter_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_clk_en,
  output logic [1:0]  o_phase,
  output logic [3:0]  o_phases,
  output logic [31:0] o_cycle_ctr
);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_phase     <= PHASE_ARB;
      o_cycle_ctr <= '0;
    end else if (i_clk_en) begin
      o_phase <= o_phase + 2'd1;
      if (o_phase == PHASE_LAST) o_cycle_ctr <= o_cycle_ctr + 32'd1;
    end
  end

  assign o_phases = phase_onehot(o_phase);

endmodule

// File: rtl/saturn_bus_arbiter.sv
// Saturn nibble-bus arbiter: grants instruction fetch or data access at phase 0,
// runs one ADDR/WAIT/DONE bus transaction with timeout. Define
// SATURN_BUS_ARB_FAIRNESS_EN to let a starved fetch win over data.
module saturn_bus_arbiter
  import saturn_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int WAIT_TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_clk_en,
  output logic [3:0]  o_phases,
  output logic [1:0]  o_phase,
  output logic [31:0] o_cycle_ctr,
  input  logic        i_fetch_req,
  input  logic [19:0] i_fetch_addr,
  output logic        o_fetch_ack,
  output logic [3:0]  o_fetch_nibble,
  input  logic        i_data_req,
  input  logic        i_data_we,
  input  logic [19:0] i_data_addr,
  input  logic [3:0]  i_data_wdata,
  output logic        o_data_ack,
  output logic [3:0]  o_data_rdata,
  output logic        o_bus_strobe,
  output logic        o_bus_we,
  output logic [19:0] o_bus_addr,
  output logic [3:0]  o_bus_wdata,
  input  logic        i_bus_ready,
  input  logic [3:0]  i_bus_rdata,
  output logic        o_bus_busy,
  output logic        o_bus_error
);

  arb_state_t state_q, state_d;
  owner_t     owner_q;
  logic [7:0] wait_cnt_q;
  logic       at_arb, starved, grant_data, grant_fetch, wait_timeout;

  saturn_phase_gen u_phase_gen (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_clk_en    (i_clk_en),
    .o_phase     (o_phase),
    .o_phases    (o_phases),
    .o_cycle_ctr (o_cycle_ctr)
  );

  assign at_arb       = i_clk_en && (o_phase == PHASE_ARB) && (state_q == ST_IDLE);
  assign grant_data   = at_arb && i_data_req && !(i_fetch_req && starved);
  assign grant_fetch  = at_arb && i_fetch_req && !grant_data;
  assign wait_timeout = (wait_cnt_q == 8'(WAIT_TIMEOUT - 1));

`ifdef SATURN_BUS_ARB_FAIRNESS_EN
  logic [3:0] starve_q;

  assign starved = (starve_q == 4'(STARVE_LIMIT));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      starve_q <= '0;
    end else if (i_clk_en) begin
      if (!i_fetch_req || grant_fetch) starve_q <= '0;
      else if (grant_data && !starved) starve_q <= starve_q + 4'd1;
    end
  end
`else
  logic [3:0] starve_limit_unused;

  assign starved             = 1'b0;
  assign starve_limit_unused = 4'(STARVE_LIMIT);
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    o_bus_strobe = 1'b0;
    o_fetch_ack  = 1'b0;
    o_data_ack   = 1'b0;
    case (state_q)
      ST_IDLE: if (grant_data || grant_fetch) state_d = ST_ADDR;
      ST_ADDR: begin
        o_bus_strobe = 1'b1;
        if (i_clk_en) state_d = ST_WAIT;
      end
      ST_WAIT: if (i_clk_en && (i_bus_ready || wait_timeout)) state_d = ST_DONE;
      ST_DONE: begin
        o_fetch_ack = (owner_q == OWNER_FETCH);
        o_data_ack  = (owner_q == OWNER_DATA);
        if (i_clk_en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write transactions leave the read-data outputs untouched, even on timeout.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      owner_q        <= OWNER_FETCH;
      wait_cnt_q     <= '0;
      o_bus_we       <= 1'b0;
      o_bus_addr     <= '0;
      o_bus_wdata    <= '0;
      o_bus_busy     <= 1'b0;
      o_bus_error    <= 1'b0;
      o_fetch_nibble <= '0;
      o_data_rdata   <= '0;
    end else if (i_clk_en) begin
      case (state_q)
        ST_IDLE: begin
          if (grant_data) begin
            owner_q     <= OWNER_DATA;
            o_bus_addr  <= i_data_addr;
            o_bus_we    <= i_data_we;
            o_bus_wdata <= i_data_wdata;
            o_bus_busy  <= 1'b1;
          end else if (grant_fetch) begin
            owner_q     <= OWNER_FETCH;
            o_bus_addr  <= i_fetch_addr;
            o_bus_we    <= 1'b0;
            o_bus_wdata <= '0;
            o_bus_busy  <= 1'b1;
          end
        end
        ST_ADDR: wait_cnt_q <= '0;
        ST_WAIT: begin
          if (i_bus_ready) begin
            if (!o_bus_we) begin
              if (owner_q == OWNER_FETCH) o_fetch_nibble <= i_bus_rdata;
              else                        o_data_rdata   <= i_bus_rdata;
            end
          end else if (wait_timeout) begin
            o_bus_error <= 1'b1;
            if (!o_bus_we) begin
              if (owner_q == OWNER_FETCH) o_fetch_nibble <= 4'h0;
              else                        o_data_rdata   <= 4'h0;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        ST_DONE: o_bus_busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_saturn_bus_arbiter.sv
// Directed bench for saturn_bus_arbiter: a vector table run with constant and
// toggling clock enable, plus arbitration-fairness, timeout and reset sequences.
module tb_saturn_bus_arbiter;

  logic        clk = 1'b0;
  logic        i_reset_n, i_clk_en;
  logic [3:0]  o_phases;
  logic [1:0]  o_phase;
  logic [31:0] o_cycle_ctr;
  logic        i_fetch_req, o_fetch_ack;
  logic [19:0] i_fetch_addr;
  logic [3:0]  o_fetch_nibble;
  logic        i_data_req, i_data_we, o_data_ack;
  logic [19:0] i_data_addr;
  logic [3:0]  i_data_wdata, o_data_rdata;
  logic        o_bus_strobe, o_bus_we;
  logic [19:0] o_bus_addr;
  logic [3:0]  o_bus_wdata;
  logic        i_bus_ready;
  logic [3:0]  i_bus_rdata;
  logic        o_bus_busy, o_bus_error;

  int vec_count   = 0;
  int miscompares = 0;

  localparam logic [19:0] FETCH_ADDR = 20'h00100;
  localparam logic [19:0] DATA_ADDR  = 20'h12345;
  localparam logic [3:0]  DATA_WDATA = 4'hA;
  localparam int          NVEC       = 22;

  typedef struct {
    logic       fetch_req;
    logic       data_req;
    logic       data_we;
    logic       bus_ready;
    logic [3:0] bus_rdata;
    logic       exp_strobe;
    logic       exp_busy;
    logic       exp_fetch_ack;
    logic       exp_data_ack;
    logic [3:0] exp_nibble;
    logic [3:0] exp_rdata;
    logic       exp_we;
  } vec_t;

  vec_t vecs [NVEC];
  logic exp_order [10];

  saturn_bus_arbiter #(.STARVE_LIMIT(4), .WAIT_TIMEOUT(15)) dut (
    .i_clk          (clk),
    .i_reset_n      (i_reset_n),
    .i_clk_en       (i_clk_en),
    .o_phases       (o_phases),
    .o_phase        (o_phase),
    .o_cycle_ctr    (o_cycle_ctr),
    .i_fetch_req    (i_fetch_req),
    .i_fetch_addr   (i_fetch_addr),
    .o_fetch_ack    (o_fetch_ack),
    .o_fetch_nibble (o_fetch_nibble),
    .i_data_req     (i_data_req),
    .i_data_we      (i_data_we),
    .i_data_addr    (i_data_addr),
    .i_data_wdata   (i_data_wdata),
    .o_data_ack     (o_data_ack),
    .o_data_rdata   (o_data_rdata),
    .o_bus_strobe   (o_bus_strobe),
    .o_bus_we       (o_bus_we),
    .o_bus_addr     (o_bus_addr),
    .o_bus_wdata    (o_bus_wdata),
    .i_bus_ready    (i_bus_ready),
    .i_bus_rdata    (i_bus_rdata),
    .o_bus_busy     (o_bus_busy),
    .o_bus_error    (o_bus_error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input logic en);
    i_clk_en    = en;
    i_fetch_req = v.fetch_req;
    i_data_req  = v.data_req;
    i_data_we   = v.data_we;
    i_bus_ready = v.bus_ready;
    i_bus_rdata = v.bus_rdata;
    @(posedge clk);
    #1;
  endtask

  task automatic checkRow(input int k, input string tag);
    vec_t       v;
    logic [1:0] ph;
    v  = vecs[k];
    ph = 2'((k + 1) % 4);
    checkOutput($sformatf("%s_r%0d_phase", tag, k), 32'(o_phase), 32'(ph));
    checkOutput($sformatf("%s_r%0d_phases", tag, k), 32'(o_phases), 32'(4'b0001 << ph));
    checkOutput($sformatf("%s_r%0d_cycle", tag, k), o_cycle_ctr, 32'((k + 1) / 4));
    checkOutput($sformatf("%s_r%0d_strobe", tag, k), 32'(o_bus_strobe), 32'(v.exp_strobe));
    checkOutput($sformatf("%s_r%0d_busy", tag, k), 32'(o_bus_busy), 32'(v.exp_busy));
    checkOutput($sformatf("%s_r%0d_fack", tag, k), 32'(o_fetch_ack), 32'(v.exp_fetch_ack));
    checkOutput($sformatf("%s_r%0d_dack", tag, k), 32'(o_data_ack), 32'(v.exp_data_ack));
    checkOutput($sformatf("%s_r%0d_nibble", tag, k), 32'(o_fetch_nibble), 32'(v.exp_nibble));
    checkOutput($sformatf("%s_r%0d_rdata", tag, k), 32'(o_data_rdata), 32'(v.exp_rdata));
    checkOutput($sformatf("%s_r%0d_error", tag, k), 32'(o_bus_error), 32'd0);
    if (v.exp_strobe) begin
      checkOutput($sformatf("%s_r%0d_addr", tag, k), 32'(o_bus_addr),
                  32'(v.data_req ? DATA_ADDR : FETCH_ADDR));
      checkOutput($sformatf("%s_r%0d_we", tag, k), 32'(o_bus_we), 32'(v.exp_we));
      if (v.exp_we)
        checkOutput($sformatf("%s_r%0d_wdata", tag, k), 32'(o_bus_wdata), 32'(DATA_WDATA));
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_phase"}, 32'(o_phase), 32'd0);
    checkOutput({tag, "_phases"}, 32'(o_phases), 32'h1);
    checkOutput({tag, "_cycle"}, o_cycle_ctr, 32'd0);
    checkOutput({tag, "_strobe"}, 32'(o_bus_strobe), 32'd0);
    checkOutput({tag, "_we"}, 32'(o_bus_we), 32'd0);
    checkOutput({tag, "_addr"}, 32'(o_bus_addr), 32'd0);
    checkOutput({tag, "_wdata"}, 32'(o_bus_wdata), 32'd0);
    checkOutput({tag, "_acks"}, 32'({o_fetch_ack, o_data_ack}), 32'd0);
    checkOutput({tag, "_nibble"}, 32'(o_fetch_nibble), 32'd0);
    checkOutput({tag, "_rdata"}, 32'(o_data_rdata), 32'd0);
    checkOutput({tag, "_busy"}, 32'(o_bus_busy), 32'd0);
    checkOutput({tag, "_error"}, 32'(o_bus_error), 32'd0);
  endtask

  task automatic waitIdlePhase0(input string tag);
    int n = 0;
    while (!(o_phase == 2'd0 && !o_bus_busy) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) checkOutput({tag, "_idle_wait"}, 32'(n), 32'd0);
    @(negedge clk);
  endtask

  task automatic idleInputs();
    i_clk_en    = 1'b1;
    i_fetch_req = 1'b0;
    i_data_req  = 1'b0;
    i_data_we   = 1'b0;
    i_bus_ready = 1'b0;
    i_bus_rdata = 4'h0;
  endtask

  initial begin
    int n, cyc, acks;

    //                fetch data  we    rdy   rdata  strb  busy  fack  dack  nib   rdat  ewe
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'h6, 1'b0, 1'b1, 1'b1, 1'b0, 4'h6, 4'h0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 4'h0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h6, 4'h0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h6, 4'h0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h6, 4'h0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 1'b1, 4'h6, 4'h0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 4'h0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 4'h0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 4'h0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 4'h0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h6, 4'h0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h6, 4'h0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h9, 1'b0, 1'b1, 1'b0, 1'b1, 4'h6, 4'h9, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 4'h9, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 4'h9, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 4'h9, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 4'h9, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 4'h9, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 4'h9, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 4'h9, 1'b0};

    // 1 = data grant, 0 = fetch grant
    for (int i = 0; i < 10; i++) begin
`ifdef SATURN_BUS_ARB_FAIRNESS_EN
      exp_order[i] = (i % 5) != 4;
`else
      exp_order[i] = 1'b1;
`endif
    end

    i_fetch_addr = FETCH_ADDR;
    i_data_addr  = DATA_ADDR;
    i_data_wdata = DATA_WDATA;
    idleInputs();
    i_reset_n = 1'b0;
    #1;
    checkReset("reset_async");
    @(negedge clk);
    @(negedge clk);
    checkReset("reset_held");
    i_reset_n = 1'b1;

    $display("[TB] table pass, clock enable constant");
    for (int k = 0; k < NVEC; k++) begin
      applyStimulus(vecs[k], 1'b1);
      checkRow(k, "en");
      @(negedge clk);
    end
    idleInputs();

    $display("[TB] arbitration order with both requests held");
    waitIdlePhase0("fair");
    i_fetch_req = 1'b1;
    i_data_req  = 1'b1;
    i_data_we   = 1'b0;
    i_bus_ready = 1'b1;
    i_bus_rdata = 4'h7;
    n   = 0;
    cyc = 0;
    while (n < 10 && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
      if (o_fetch_ack || o_data_ack) begin
        checkOutput($sformatf("grant_order_%0d", n), 32'(o_data_ack), 32'(exp_order[n]));
        n++;
      end
    end
    if (n < 10) checkOutput("grant_order_count", 32'(n), 32'd10);
    @(negedge clk);
    idleInputs();

    $display("[TB] wait timeout");
    waitIdlePhase0("timeout");
    i_fetch_req = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("timeout_strobe", 32'(o_bus_strobe), 32'd1);
    cyc = 0;
    while (!o_fetch_ack && cyc < 100) begin
      if (cyc == 15) checkOutput("timeout_err_early", 32'(o_bus_error), 32'd0);
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("timeout_cycles", 32'(cyc), 32'd16);
    checkOutput("timeout_error", 32'(o_bus_error), 32'd1);
    checkOutput("timeout_nibble", 32'(o_fetch_nibble), 32'd0);
    checkOutput("timeout_busy", 32'(o_bus_busy), 32'd1);
    @(negedge clk);
    i_fetch_req = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("timeout_busy_drop", 32'(o_bus_busy), 32'd0);
    checkOutput("timeout_ack_single", 32'(o_fetch_ack), 32'd0);
    checkOutput("timeout_error_sticky", 32'(o_bus_error), 32'd1);

    $display("[TB] reset during wait");
    waitIdlePhase0("rst");
    i_data_req = 1'b1;
    i_data_we  = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_strobe", 32'(o_bus_strobe), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #2;
    checkOutput("rst_busy_pre", 32'(o_bus_busy), 32'd1);
    i_reset_n = 1'b0;
    #1;
    checkReset("rst_midwait");
    i_data_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i_reset_n = 1'b1;
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      acks += int'(o_fetch_ack) + int'(o_data_ack);
    end
    checkOutput("rst_no_ack", 32'(acks), 32'd0);
    waitIdlePhase0("rst_next");
    i_data_req  = 1'b1;
    i_bus_ready = 1'b1;
    i_bus_rdata = 4'h5;
    cyc = 0;
    while (!o_data_ack && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("rst_next_ack", 32'(o_data_ack), 32'd1);
    checkOutput("rst_next_rdata", 32'(o_data_rdata), 32'h5);
    checkOutput("rst_next_error", 32'(o_bus_error), 32'd0);
    @(negedge clk);
    idleInputs();

    $display("[TB] table pass, clock enable toggling");
    @(negedge clk);
    i_reset_n = 1'b0;
    #1;
    checkReset("reset_pass2");
    @(negedge clk);
    i_reset_n = 1'b1;
    for (int k = 0; k < NVEC; k++) begin
      applyStimulus(vecs[k], 1'b1);
      checkRow(k, "tog_en");
      @(negedge clk);
      applyStimulus(vecs[k], 1'b0);
      checkRow(k, "tog_dis");
      @(negedge clk);
    end
    idleInputs();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/saturn_bus_arbiter.md
SATURN_BUS_ARBITER -- requirements
Module: saturn_bus_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, max consecutive data grants while fetch is pending (range 1..15).
REQ-002 Parameter: WAIT_TIMEOUT, default 15, max clock-enabled cycles in WAIT before abort (range 1..255).
REQ-003 i_clk  in  1  single clock, all logic on rising edge.
REQ-004 i_reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 i_clk_en  in  1  global clock enable; no state changes when low, except reset.
REQ-006 o_phases  out  4  one-hot phase strobe, bit n set when o_phase==n.
REQ-007 o_phase  out  2  current phase 0..3.
REQ-008 o_cycle_ctr  out  32  count of completed 4-phase cycles.
REQ-009 i_fetch_req / i_fetch_addr  in  1 / 20  instruction nibble read request, PC address.
REQ-010 o_fetch_ack / o_fetch_nibble  out  1 / 4  one-cycle completion pulse, read data.
REQ-011 i_data_req / i_data_we / i_data_addr / i_data_wdata  in  1 / 1 / 20 / 4  data access request.
REQ-012 o_data_ack / o_data_rdata  out  1 / 4  one-cycle completion pulse, read data.
REQ-013 o_bus_strobe / o_bus_we / o_bus_addr / o_bus_wdata  out  1 / 1 / 20 / 4  external nibble-bus command.
REQ-014 i_bus_ready / i_bus_rdata  in  1 / 4  bus target completion, read data valid with ready.
REQ-015 o_bus_busy  out  1  high from grant until the cycle after ack; consumed by the decoder as i_bus_busy.
REQ-016 o_bus_error  out  1  sticky timeout flag.

Function
REQ-017 Phase counter: o_phase increments mod 4 on every i_clk_en cycle, free-running, independent of bus state.
REQ-018 o_cycle_ctr increments by 1, wrapping at 2^32, on each i_clk_en cycle where o_phase goes 3->0.
REQ-019 FSM states IDLE, ADDR, WAIT, DONE; transitions only on i_clk_en cycles.
REQ-020 IDLE: arbitrates only when o_phase==0; no request -> stay IDLE.
REQ-021 Grant: data wins over fetch, except fetch wins when both pending and starve counter == STARVE_LIMIT.
REQ-022 Starve counter: +1 per data grant while fetch pending, saturating at STARVE_LIMIT; cleared on fetch grant or when fetch not pending.
REQ-023 On grant: latch address/we/wdata/owner, o_bus_busy<=1, go ADDR.
REQ-024 ADDR: o_bus_strobe=1 for exactly one clock-enabled cycle, go WAIT.
REQ-025 WAIT: i_bus_ready=1 -> latch i_bus_rdata to owner's data output, go DONE; ready sampled only in WAIT.
REQ-026 WAIT timeout: WAIT_TIMEOUT enabled cycles without ready -> o_bus_error<=1, go DONE, data output = 4'h0.
REQ-027 DONE: owner ack=1 for one clock-enabled cycle, go IDLE; o_bus_busy drops on the next enabled cycle.
REQ-028 Requests are level-held by requesters until ack; a request dropped before grant is ignored; after grant the transaction always completes.
REQ-029 Simultaneous fetch and data at phase 0 with counter below limit: data granted, fetch waits the next phase-0 window.
REQ-030 Write transactions: o_bus_we=1, read data outputs hold their previous values.
REQ-031 Worst-case latency request-to-ack with ready immediate: arbitration wait up to 3 + 3 enabled cycles.

Reset
REQ-032 On i_reset_n low: o_phase=0, o_phases=4'b0001, o_cycle_ctr=0, FSM=IDLE, all acks/strobe/we=0, addresses/data=0, o_bus_busy=0, o_bus_error=0, starve counter=0.
REQ-033 Reset mid-transaction aborts it silently; no ack is issued for the aborted request.

Configuration
REQ-034 Macro SATURN_BUS_ARB_FAIRNESS_EN defined: starve counter and REQ-021 exception active.
REQ-035 Macro undefined: strict data priority, no starve counter logic; STARVE_LIMIT unused.

Structure
REQ-036 Shared package holds FSM state encodings, owner codes (FETCH/DATA), phase constants.
REQ-037 One natural sub-module: saturn_phase_gen (phase, one-hot phases, cycle counter).

Verification
REQ-038 Reset release, i_clk_en=1 constant -> o_phases 0001,0010,0100,1000 repeating; o_cycle_ctr=1 after 4 enabled cycles.
REQ-039 Fetch addr 20'h00100, ready in first WAIT, rdata 4'h6 -> o_fetch_nibble=6, single o_fetch_ack pulse, o_bus_busy high throughout.
REQ-040 Data and fetch held continuously, FAIRNESS_EN, STARVE_LIMIT=4 -> grant order D,D,D,D,F,D,D,D,D,F; macro undefined -> D only.
REQ-041 i_bus_ready never asserted, WAIT_TIMEOUT=15 -> o_bus_error=1 after 15 WAIT cycles, ack with data 4'h0, FSM back to IDLE.
REQ-042 i_reset_n low during WAIT -> all outputs reset immediately, no ack; next request serviced normally.
REQ-043 i_clk_en toggled 1/0 every clock -> behavior identical to constant-enable run in enabled-cycle count.
